matrix_mul_seq: RTL and testbench

MATRIX_MUL_SEQ -- requirements
Module: matrix_mul_seq

---
 rtl/matrix_pkg.sv | 22 ++
 rtl/matrix_row_comp.sv | 84 ++++++++
 rtl/matrix_mul_seq.sv | 140 ++++++++++++++
 tb/tb_matrix_mul_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, FSM encoding and element addressing for the 4x4
// single-precision matrix multiplier.
package matrix_pkg;

    localparam int N      = 4;
    localparam int ELEM_W = 32;
    localparam int ROW_W  = N * ELEM_W;   // 128
    localparam int MAT_W  = N * ROW_W;    // 512

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Bit offset of element [r][c] inside a packed MAT_W matrix.
    function automatic int elem_off(input int r, input int c);
        return ELEM_W * (N * r + c);
    endfunction

endpackage

// File: rtl/matrix_row_comp.sv
// Single-precision dot product of one row of A with one column of B.
// Ports:
//   row_op  - A[r][k] at bits 32k
//   col_op  - B[k][c] at bits 32k
//   result  - sum over k of row_op[k]*col_op[k], IEEE-754 single
//   rdy     - result valid (always 1: the datapath is purely combinational)
// Arithmetic truncates (round toward zero), flushes subnormals to zero
// and saturates overflow to infinity; NaN inputs are not special-cased.
module matrix_row_comp
    import matrix_pkg::*;
(
    input  logic [ROW_W-1:0]  row_op,
    input  logic [ROW_W-1:0]  col_op,
    output logic [ELEM_W-1:0] result,
    output logic              rdy
);

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        logic [47:0]       p;
        logic signed [9:0] e;
        logic [22:0]       f;
        s = a[31] ^ b[31];
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        // Product of two [1,2) mantissas lies in [1,4); renormalise once.
        if (p[47]) begin
            f = p[46:24];
            e = e + 10'sd1;
        end else begin
            f = p[45:23];
        end
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 10'sd0) return {s, 31'd0};
        if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
        return {s, e[7:0], f};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       x, y;
        logic [7:0]        d;
        logic [26:0]       mx, my;
        logic [27:0]       m;
        logic signed [9:0] e;
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        // x is the larger magnitude, so the result takes its sign.
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else                    begin x = b; y = a; end
        d  = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        my = (d > 8'd26) ? 27'd0 : (my >> d);
        e  = $signed({2'b00, x[30:23]});
        if (x[31] == y[31]) m = {1'b0, mx} + {1'b0, my};
        else                m = {1'b0, mx} - {1'b0, my};
        if (m == 28'd0) return 32'd0;
        if (m[27]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
        // Cancellation can leave leading zeros; m is nonzero so this ends.
        for (int i = 0; i < 26; i++) begin
            if (!m[26]) begin
                m = m << 1;
                e = e - 10'sd1;
            end
        end
        if (e <= 10'sd0) return {x[31], 31'd0};
        if (e >= 10'sd255) return {x[31], 8'hFF, 23'd0};
        return {x[31], e[7:0], m[25:3]};
    endfunction

    logic [N-1:0][ELEM_W-1:0] prod;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            prod[k] = fp_mul(row_op[ELEM_W*k +: ELEM_W], col_op[ELEM_W*k +: ELEM_W]);
        end
    end

    assign result = fp_add(fp_add(prod[0], prod[1]), fp_add(prod[2], prod[3]));
    assign rdy    = 1'b1;

endmodule

// File: rtl/matrix_mul_seq.sv
// Sequential 4x4 single-precision matrix multiply, one C element at a time.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   start    - begin an operation (only honoured in IDLE)
//   a_mat    - A, element [r][c] at bits 32*(4r+c)
//   b_mat    - B, same layout
//   c_mat    - C = A x B, same layout, updated element by element
//   busy     - high outside IDLE
//   done     - one-cycle pulse on completion or timeout abort
//   err      - sticky timeout flag, cleared by the next accepted start
module matrix_mul_seq
    import matrix_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [MAT_W-1:0] a_mat,
    input  logic [MAT_W-1:0] b_mat,
    output logic [MAT_W-1:0] c_mat,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    // One extra bit so counter+1 can reach TIMEOUT without wrapping.
    localparam logic [CNT_W:0] SETTLE_L  = (CNT_W+1)'(SETTLE_CYCLES);
    localparam logic [CNT_W:0] TIMEOUT_L = (CNT_W+1)'(TIMEOUT);

    state_t             state_q, state_d;
    logic [MAT_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [ROW_W-1:0]   row_q, row_d, col_q, col_d;
    logic [3:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [CNT_W:0]     cnt_inc;
    logic [ROW_W-1:0]   col_gather;
    logic [ELEM_W-1:0]  comp_result;
    logic               comp_rdy;

    matrix_row_comp u_row_comp (
        .row_op (row_q),
        .col_op (col_q),
        .result (comp_result),
        .rdy    (comp_rdy)
    );

    // Column c of the latched B, re-packed so B[k][c] sits at bits 32k.
    always_comb begin
        col_gather = '0;
        for (int k = 0; k < N; k++) begin
            col_gather[ELEM_W*k +: ELEM_W] = b_q[elem_off(k, int'(idx_q[1:0])) +: ELEM_W];
        end
    end

    assign cnt_inc = {1'b0, cnt_q} + 1'b1;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        row_d   = row_q;
        col_d   = col_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_mat;
                    b_d     = b_mat;
                    err_d   = 1'b0;
                    idx_d   = 4'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Operands are registered here and held through WAIT.
                row_d   = a_q[ROW_W*int'(idx_q[3:2]) +: ROW_W];
                col_d   = col_gather;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_inc >= SETTLE_L && comp_rdy) begin
                    c_d[ELEM_W*int'(idx_q) +: ELEM_W] = comp_result;
                    if (idx_q == 4'd15) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_ISSUE;
                    end
                end else if (cnt_inc == TIMEOUT_L) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            row_q   <= row_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign c_mat = c_q;
    assign err   = err_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_matrix_mul_seq.sv
module tb_matrix_mul_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [511:0] a_mat = '0;
    logic [511:0] b_mat = '0;
    logic [511:0] c_mat;
    logic         busy, done, err;

    matrix_mul_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_mat (a_mat),
        .b_mat (b_mat),
        .c_mat (c_mat),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [511:0] c;
        logic         e;
        int           lat;
        int           st;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   done_cnt = 0;

    // float(0..15), hand-encoded
    logic [31:0] fseq [16] = '{
        32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
        32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
        32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
        32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000};

    logic [511:0] ident, diag2, seq_m, ones, twos;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Monitor: every done pulse pops one expectation.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("c_mat", c_mat, e.c);
                    chk("err_at_done", 512'(err), 512'(e.e));
                    chk("done_latency", 512'(cyc - e.st + 1), 512'(e.lat));
                end
            end
        end
    end

    task automatic start_op(input logic [511:0] a, input logic [511:0] b,
                            input logic [511:0] ec, input logic ee, input int el, input bit push);
        exp_t e;
        @(negedge clk);
        a_mat = a; b_mat = b; start = 1'b1;
        @(posedge clk); #1;
        if (push) begin
            e.c = ec; e.e = ee; e.lat = el; e.st = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n0;
        bit seen;
        n0 = done_cnt;
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done_cnt != n0) seen = 1;
        end
        if (!seen) begin
            n_chk++;
            $display("FAIL done_timeout: got no done within %0d cycles want done", bound);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ident[32*i +: 32] = (i % 5 == 0) ? 32'h3F800000 : 32'h0;
            diag2[32*i +: 32] = (i % 5 == 0) ? 32'h40000000 : 32'h0;
            seq_m[32*i +: 32] = fseq[i];
            ones[32*i +: 32]  = 32'h3F800000;
            twos[32*i +: 32]  = 32'h40000000;
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_err", 512'(err), 512'(0));
        chk("rst_c_mat", c_mat, 512'(0));

        // Identity: C == B bit-exact, done in cycle 49
        start_op(ident, seq_m, seq_m, 1'b0, 49, 1);
        wait_done(200);

        // Scaling: diag(2) x ones -> all 2.0
        start_op(diag2, ones, twos, 1'b0, 49, 1);
        wait_done(200);

        // Input hold + ignored start while busy
        start_op(ident, seq_m, seq_m, 1'b0, 49, 1);
        repeat (4) @(negedge clk);
        a_mat = diag2;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);
        repeat (60) @(negedge clk);
        chk("hold_idle_busy", 512'(busy), 512'(0));

        // Reset mid-operation: no done, outputs cleared
        start_op(diag2, ones, twos, 1'b0, 49, 0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", 512'(busy), 512'(0));
        chk("midrst_c_mat", c_mat, 512'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (70) @(negedge clk);
        start_op(diag2, ones, twos, 1'b0, 49, 1);
        wait_done(200);

        // Timeout: rdy stuck low, c_mat keeps previous contents
        force dut.comp_rdy = 1'b0;
        start_op(ident, seq_m, twos, 1'b1, 66, 1);
        wait_done(200);
        release dut.comp_rdy;
        repeat (5) @(negedge clk);
        chk("err_sticky", 512'(err), 512'(1));

        // Next start clears err
        start_op(ident, seq_m, seq_m, 1'b0, 49, 1);
        wait_done(200);

        chk("scoreboard_empty", 512'(sb.size()), 512'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
